// File: rtl/zjh_cc_tf_conv.sv
// rtl/zjh_cc_tf_conv.sv - registered two's-complement to sign-magnitude converter
module zjh_cc_tf_conv #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_ovf_o,
    input  logic             clr_stats_i,
    output logic [CNT_W-1:0] conv_cnt_o,
    output logic [CNT_W-1:0] ovf_cnt_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] conv_cnt_q, conv_cnt_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic             in_sign;
    logic [WIDTH-2:0] in_mag;
    logic [WIDTH-2:0] neg_mag;
    logic [WIDTH-1:0] conv_data;
    logic             conv_ovf;
    logic             accept;
    logic             deliver;

    // The most negative input negates to zero magnitude, which yields the
    // negative-zero code on its own; only the overflow flag marks it.
    assign in_sign   = in_data_i[WIDTH-1];
    assign in_mag    = in_data_i[WIDTH-2:0];
    assign neg_mag   = (~in_mag) + (WIDTH-1)'(1);
    assign conv_data = in_sign ? {1'b1, neg_mag} : in_data_i;
    assign conv_ovf  = in_sign && (in_mag == '0);

    assign in_ready_o = !valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign deliver    = valid_q && out_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        if (accept) begin
            valid_d = 1'b1;
            data_d  = conv_data;
            ovf_d   = conv_ovf;
        end else if (deliver) begin
            valid_d = 1'b0;
        end
    end

    // Statistics follow the sink handshake; a clear in the same cycle wins.
    always_comb begin
        conv_cnt_d = conv_cnt_q;
        ovf_cnt_d  = ovf_cnt_q;
        if (clr_stats_i) begin
            conv_cnt_d = '0;
            ovf_cnt_d  = '0;
        end else if (deliver) begin
            conv_cnt_d = conv_cnt_q + CNT_W'(1);
            if (ovf_q && (ovf_cnt_q != '1)) begin
                ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            data_q     <= '0;
            ovf_q      <= 1'b0;
            conv_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            valid_q    <= valid_d;
            data_q     <= data_d;
            ovf_q      <= ovf_d;
            conv_cnt_q <= conv_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_ovf_o   = ovf_q;
    assign conv_cnt_o  = conv_cnt_q;
    assign ovf_cnt_o   = ovf_cnt_q;

endmodule

// File: doc/zjh_cc_tf_conv.md
Name: zjh_cc_tf_conv

Overview:
Registered complement-to-true-form converter. Accepts WIDTH-bit two's-complement words and emits sign-magnitude (true form) words, performing the inverse of the team's combinational true-form-to-complement converter. It sits between a data source and sink on a valid/ready stream, with one pipeline register, full-throughput backpressure, and conversion/overflow statistics.

Parameters:
WIDTH, 4, data word width in bits, including the sign bit; legal range 2..16.
CNT_W, 8, width of the statistics counters.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  source presents in_data this cycle.
in_ready  out  1  block accepts in_data this cycle.
in_data  in  WIDTH  two's-complement input word.
out_valid  out  1  out_data/out_ovf hold a converted word.
out_ready  in  1  sink accepts the output word this cycle.
out_data  out  WIDTH  sign-magnitude result; MSB is sign, [WIDTH-2:0] is magnitude.
out_ovf  out  1  result is not representable (input was -2^(WIDTH-1)).
clr_stats  in  1  synchronous clear of both counters.
conv_cnt  out  CNT_W  words delivered to the sink; wraps modulo 2^CNT_W.
ovf_cnt  out  CNT_W  overflow words delivered to the sink; saturates at all-ones.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_ovf=0, conv_cnt=0, ovf_cnt=0. Reset overrides all activity; an in-flight word is discarded and not counted.
- in_ready is combinational: in_ready = !out_valid || out_ready. It does not depend on in_valid.
- Accept: when in_valid && in_ready at an edge, the output register loads the converted word and out_valid becomes 1. Latency is exactly 1 cycle.
- Deliver: when out_valid && out_ready at an edge, the word is consumed. If no new accept occurs in the same cycle, out_valid goes to 0.
- Simultaneous deliver and accept: the register reloads with the new word and out_valid stays 1. This gives a sustained throughput of 1 word per clock.
- Stall: while out_valid=1 and out_ready=0, out_data and out_ovf hold stable and in_ready=0.
- Conversion, with s = in_data[WIDTH-1] and m = in_data[WIDTH-2:0]:
  - s=0: out_data = in_data, out_ovf=0.
  - s=1, m!=0: out_data = {1, (~m + 1) truncated to WIDTH-1 bits}, out_ovf=0.
  - s=1, m=0 (most negative value): out_data = {1, zeros} ("negative zero" code), out_ovf=1.
  - The output never carries a negative zero except in the overflow case.
- Counters advance on the deliver handshake (out_valid && out_ready), not on accept:
  - conv_cnt increments by 1 and wraps from all-ones to 0.
  - ovf_cnt increments by 1 when out_ovf=1 and holds at all-ones.
- clr_stats=1 at an edge sets both counters to 0. A deliver in the same cycle is not counted, because clear wins. The data path is unaffected by clr_stats.
- out_data and out_ovf are don't-care while out_valid=0 but are held at their last value. No combinational path exists from in_data to the outputs.

Test Plan:
1. Reset, then in_data=4'b1101 (-3) with out_ready=1 -> next cycle out_valid=1, out_data=4'b1011, out_ovf=0; conv_cnt=1 after delivery.
2. Back-to-back stream 0101, 0000, 1111, 0111 with out_ready held at 1 -> outputs 0101, 0000, 1001, 0111 on consecutive cycles; in_ready stays 1; conv_cnt=4.
3. in_data=4'b1000 -> out_data=4'b1000, out_ovf=1; after delivery ovf_cnt=1 and conv_cnt=1.
4. Backpressure: accept 1110, hold out_ready=0 for 3 cycles while in_valid=1 with 0011 -> in_ready=0 and out_data stays 1010 throughout. After out_ready=1, 0011 follows on the next cycle with no loss and no duplication.
5. Counter limits with CNT_W=2: deliver five 1000 words -> ovf_cnt saturates at 3 and conv_cnt wraps to 1. Assert clr_stats in the same cycle as a delivery -> both counters read 0.
6. Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, all counters 0, in_ready=1; the held word is never delivered.
